// File: rtl/dw_scan_ctrl.sv
// dw_scan_ctrl: raster scan controller for the depthwise-convolution stage.
// Walks every output pixel of a square map of side `matrix`, presenting the
// nine 3x3 tap addresses per pixel with zero-pad flags, plus the center
// index `i` and its border code `prov`. All outputs are registered.
// Optional feature macro: DW_SCAN_STRIDE2_EN adds a `stride2` input that
// visits only even-row/even-column centers.
module dw_scan_ctrl #(
  parameter int ADDR_W = 15,
  parameter int SIZE_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [SIZE_W-1:0] matrix,
`ifdef DW_SCAN_STRIDE2_EN
  input  logic              stride2,
`endif
  input  logic              stall,
  output logic              busy,
  output logic              tap_valid,
  output logic [3:0]        tap_idx,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              tap_pad,
  output logic [ADDR_W-1:0] i,
  output logic [1:0]        prov,
  output logic              pix_valid,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic signed [SIZE_W+1:0] S_NEG1 = '1;
  localparam logic signed [SIZE_W+1:0] S_ZERO = '0;
  localparam logic signed [SIZE_W+1:0] S_POS1 = {{(SIZE_W+1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [SIZE_W-1:0]   mat_q, mat_d, r_q, r_d, c_q, c_d;
  logic [3:0]          t_q, t_d;
  logic [ADDR_W-1:0]   rb_q, rb_d;
  logic [SIZE_W:0]     step, c_nxt, r_nxt;
  logic [ADDR_W-1:0]   rb_step;

  logic                busy_d, tap_valid_d, tap_pad_d, pix_valid_d, done_d;
  logic [3:0]          tap_idx_d;
  logic [ADDR_W-1:0]   tap_addr_d, i_d;
  logic [1:0]          prov_d;
  logic                busy_q, tap_valid_q, tap_pad_q, pix_valid_q, done_q;
  logic [3:0]          tap_idx_q;
  logic [ADDR_W-1:0]   tap_addr_q, i_q;
  logic [1:0]          prov_q;

  logic signed [SIZE_W+1:0] dy, dx, rr, cc, ms;
  logic [ADDR_W-1:0]   row_base;
  logic                pad, scan;

`ifdef DW_SCAN_STRIDE2_EN
  logic str_q, str_d;
  // Stride selects center step and row-base increment (2*matrix via shift).
  always_comb begin
    step    = str_q ? (SIZE_W+1)'(2) : (SIZE_W+1)'(1);
    rb_step = str_q ? (ADDR_W'(mat_q) << 1) : ADDR_W'(mat_q);
  end
`else
  // Fixed unit stride.
  always_comb begin
    step    = (SIZE_W+1)'(1);
    rb_step = ADDR_W'(mat_q);
  end
`endif

  // Next-state and counter stepping; counters describe the tap presented next.
  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    r_d     = r_q;
    c_d     = c_q;
    t_d     = t_q;
    rb_d    = rb_q;
    done_d  = 1'b0;
`ifdef DW_SCAN_STRIDE2_EN
    str_d   = str_q;
`endif
    c_nxt   = {1'b0, c_q} + step;
    r_nxt   = {1'b0, r_q} + step;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          mat_d = matrix;
`ifdef DW_SCAN_STRIDE2_EN
          str_d = stride2;
`endif
          r_d   = '0;
          c_d   = '0;
          t_d   = '0;
          rb_d  = '0;
          if (matrix != '0) begin
            state_d = S_SCAN;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (!stall) begin
          if (t_q == 4'd8) begin
            t_d = '0;
            if (c_nxt >= {1'b0, mat_q}) begin
              c_d = '0;
              if (r_nxt >= {1'b0, mat_q}) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                r_d  = r_nxt[SIZE_W-1:0];
                rb_d = rb_q + rb_step;
              end
            end else begin
              c_d = c_nxt[SIZE_W-1:0];
            end
          end else begin
            t_d = t_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tap geometry and registered-output values derived from the next counters.
  always_comb begin
    dy       = S_POS1;
    dx       = S_POS1;
    row_base = rb_d + ADDR_W'(mat_d);
    unique case (t_d)
      4'd0, 4'd1, 4'd2: begin dy = S_NEG1; row_base = rb_d - ADDR_W'(mat_d); end
      4'd3, 4'd4, 4'd5: begin dy = S_ZERO; row_base = rb_d; end
      default: ;
    endcase
    unique case (t_d)
      4'd0, 4'd3, 4'd6: dx = S_NEG1;
      4'd1, 4'd4, 4'd7: dx = S_ZERO;
      default: ;
    endcase
    rr   = $signed({2'b00, r_d}) + dy;
    cc   = $signed({2'b00, c_d}) + dx;
    ms   = $signed({2'b00, mat_d});
    pad  = rr[SIZE_W+1] || (rr >= ms) || cc[SIZE_W+1] || (cc >= ms);
    scan = (state_d == S_SCAN);

    busy_d      = scan;
    tap_valid_d = scan;
    tap_idx_d   = scan ? t_d : 4'd0;
    tap_pad_d   = scan && pad;
    tap_addr_d  = (scan && !pad) ? row_base + ADDR_W'(cc) : '0;
    i_d         = scan ? rb_d + ADDR_W'(c_d) : '0;
    pix_valid_d = scan && (t_d == 4'd8);
    if (!scan)                   prov_d = 2'b00;
    else if (c_d == '0)          prov_d = 2'b11;
    else if (c_d == mat_d - 1'b1) prov_d = 2'b10;
    else                         prov_d = 2'b00;
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mat_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      t_q         <= '0;
      rb_q        <= '0;
`ifdef DW_SCAN_STRIDE2_EN
      str_q       <= 1'b0;
`endif
      busy_q      <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      tap_addr_q  <= '0;
      tap_pad_q   <= 1'b0;
      i_q         <= '0;
      prov_q      <= '0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mat_q       <= mat_d;
      r_q         <= r_d;
      c_q         <= c_d;
      t_q         <= t_d;
      rb_q        <= rb_d;
`ifdef DW_SCAN_STRIDE2_EN
      str_q       <= str_d;
`endif
      busy_q      <= busy_d;
      tap_valid_q <= tap_valid_d;
      tap_idx_q   <= tap_idx_d;
      tap_addr_q  <= tap_addr_d;
      tap_pad_q   <= tap_pad_d;
      i_q         <= i_d;
      prov_q      <= prov_d;
      pix_valid_q <= pix_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign tap_valid = tap_valid_q;
  assign tap_idx   = tap_idx_q;
  assign tap_addr  = tap_addr_q;
  assign tap_pad   = tap_pad_q;
  assign i         = i_q;
  assign prov      = prov_q;
  assign pix_valid = pix_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dw_scan_ctrl.sv
// Directed bench for dw_scan_ctrl with a small reference model of the scan.
module tb_dw_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [6:0]  matrix = '0;
  logic        stall = 1'b0;
`ifdef DW_SCAN_STRIDE2_EN
  logic        stride2 = 1'b0;
`endif
  logic        busy, tap_valid, tap_pad, pix_valid, done;
  logic [3:0]  tap_idx;
  logic [14:0] tap_addr, i;
  logic [1:0]  prov;

  int passed = 0;
  int total  = 0;

  logic        a_busy[0:127], a_valid[0:127], a_pad[0:127], a_pv[0:127], a_done[0:127];
  logic [3:0]  a_idx[0:127];
  logic [14:0] a_addr[0:127], a_i[0:127];
  logic [1:0]  a_prov[0:127];

  dw_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .go(go), .matrix(matrix),
`ifdef DW_SCAN_STRIDE2_EN
    .stride2(stride2),
`endif
    .stall(stall), .busy(busy), .tap_valid(tap_valid), .tap_idx(tap_idx),
    .tap_addr(tap_addr), .tap_pad(tap_pad), .i(i), .prov(prov),
    .pix_valid(pix_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected packed outputs for tap t of pixel p on an m x m map.
  function automatic logic [40:0] model(input int m, input int p, input int t);
    int r, c, rr, cc, addr, pr;
    logic pd;
    r  = p / m;  c  = p % m;
    rr = r + t / 3 - 1;  cc = c + t % 3 - 1;
    pd = (rr < 0) || (rr >= m) || (cc < 0) || (cc >= m);
    addr = pd ? 0 : rr * m + cc;
    pr = (c == 0) ? 3 : ((c == m - 1) ? 2 : 0);
    return {1'b1, 1'b1, 1'b0, 4'(t), pd, 15'(addr), 15'(p), 2'(pr), (t == 8)};
  endfunction

  function automatic logic [40:0] observed(input int k);
    return {a_busy[k], a_valid[k], a_done[k], a_idx[k], a_pad[k], a_addr[k],
            a_i[k], a_prov[k], a_pv[k]};
  endfunction

  task automatic start_scan(input int m, input logic s2);
    @(negedge clk);
    go = 1'b1;
    matrix = 7'(m);
`ifdef DW_SCAN_STRIDE2_EN
    stride2 = s2;
`else
    if (s2) $display("stride2 request ignored in this build");
`endif
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  // Record cycles 1..n; stall drives edges s0..s1, a go pulse at edge gk.
  task automatic capture(input int n, input int s0, input int s1, input int gk, input int gm);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      a_busy[k] = busy;  a_valid[k] = tap_valid; a_done[k] = done;
      a_idx[k]  = tap_idx; a_pad[k] = tap_pad; a_addr[k] = tap_addr;
      a_i[k]    = i;     a_prov[k] = prov;     a_pv[k] = pix_valid;
      stall = (k >= s0) && (k <= s1);
      go    = (k == gk);
      if (k == gk) matrix = 7'(gm);
    end
    stall = 1'b0;
    go    = 1'b0;
  endtask

  // Compare every tap of an unstrided scan against the model.
  task automatic check_scan(input string tag, input int m, input int st_at, input int st_len);
    for (int j = 0; j < m * m * 9; j++) begin
      int k;
      k = 1 + j + ((j > st_at) ? st_len : 0);
      chk($sformatf("%s_tap%0d", tag, j), 64'(observed(k)), 64'(model(m, j / 9, j % 9)));
    end
  endtask

  function automatic logic [32:0] out_vec();
    return {busy, tap_valid, tap_idx, tap_addr, tap_pad, prov, pix_valid, done, 6'd0};
  endfunction

  initial begin
    logic [8:0]  pad_p0;
    logic [14:0] addr_p0[0:8];
    pad_p0  = 9'b001001111;  // bit t set when tap t is padded
    addr_p0 = '{0, 0, 0, 0, 0, 1, 0, 3, 4};

    // Reset state
    #2 chk("reset_outputs", 64'(out_vec()), 64'd0);
    chk("reset_i", 64'(i), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", 64'(out_vec()), 64'd0);

    // matrix=3, no stall; a stall in the done cycle must not stretch done
    start_scan(3, 1'b0);
    capture(84, 82, 82, -1, 0);
    chk("m3_c1_valid", 64'({a_busy[1], a_valid[1], a_idx[1]}), 64'({2'b11, 4'd0}));
    for (int t = 0; t < 9; t++) begin
      chk($sformatf("m3_p0_pad%0d", t), 64'(a_pad[1 + t]), 64'(pad_p0[t]));
      chk($sformatf("m3_p0_addr%0d", t), 64'(a_addr[1 + t]), 64'(addr_p0[t]));
      chk($sformatf("m3_p4_addr%0d", t), 64'({a_pad[37 + t], a_addr[37 + t]}), 64'(t));
    end
    chk("m3_p0_prov", 64'(a_prov[5]), 64'd3);
    chk("m3_p2_prov", 64'({a_i[23], a_prov[23]}), 64'({15'd2, 2'b10}));
    chk("m3_p4_prov", 64'({a_i[41], a_prov[41]}), 64'({15'd4, 2'b00}));
    chk("m3_pv8", 64'({a_pv[8], a_pv[9]}), 64'b01);
    check_scan("m3", 3, 9999, 0);
    chk("m3_done82", 64'({a_done[82], a_busy[82], a_valid[82]}), 64'b100);
    chk("m3_done83", 64'({a_done[83], a_busy[83]}), 64'b00);

    // matrix=1: one pixel, only tap 4 real
    start_scan(1, 1'b0);
    capture(11, -1, -1, -1, 0);
    for (int t = 0; t < 9; t++)
      chk($sformatf("m1_tap%0d", t), 64'({a_pad[1 + t], a_addr[1 + t], a_i[1 + t], a_prov[1 + t]}),
          64'({(t != 4), 15'd0, 15'd0, 2'b11}));
    chk("m1_done10", 64'({a_done[10], a_valid[10], a_valid[9]}), 64'b101);

    // matrix=3 with a 5-cycle stall while tap 4 of pixel 4 is shown
    start_scan(3, 1'b0);
    capture(90, 41, 45, -1, 0);
    for (int k = 41; k <= 46; k++)
      chk($sformatf("stall_hold%0d", k), 64'({a_valid[k], a_idx[k], a_addr[k]}), 64'({1'b1, 4'd4, 15'd4}));
    chk("stall_resume", 64'({a_idx[47], a_addr[47]}), 64'({4'd5, 15'd5}));
    check_scan("m3s", 3, 40, 5);
    chk("stall_done", 64'({a_done[86], a_done[87], a_busy[87]}), 64'b010);

    // matrix=4, asynchronous reset during pixel 6
    start_scan(4, 1'b0);
    capture(58, -1, -1, -1, 0);
    chk("rst_pre_i", 64'(a_i[58]), 64'd6);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_outputs", 64'(out_vec()), 64'd0);
    chk("rst_mid_i", 64'(i), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    capture(20, -1, -1, -1, 0);
    begin
      int seen = 0;
      for (int k = 1; k <= 20; k++) seen += int'(a_done[k]) + int'(a_valid[k]);
      chk("rst_no_done", 64'(seen), 64'd0);
    end
    start_scan(4, 1'b0);
    capture(3, -1, -1, -1, 0);
    chk("rst_restart", 64'({a_valid[1], a_idx[1], a_pad[1], a_i[1], a_prov[1]}),
        64'({1'b1, 4'd0, 1'b1, 15'd0, 2'b11}));
    chk("rst_restart_t2", 64'({a_idx[3], a_pad[3]}), 64'({4'd2, 1'b1}));
    repeat (150) @(negedge clk);

    // matrix=0: immediate done; a go in the done cycle is ignored
    start_scan(0, 1'b0);
    capture(4, -1, -1, 1, 3);
    chk("m0_done1", 64'({a_done[1], a_valid[1], a_busy[1]}), 64'b100);
    chk("m0_go_in_done", 64'({a_done[2], a_valid[2], a_busy[2]}), 64'b000);
    chk("m0_idle", 64'({a_valid[3], a_valid[4]}), 64'b00);

    // matrix=2 with a go (and new matrix) while busy: scan unaffected
    start_scan(2, 1'b0);
    capture(40, -1, -1, 5, 3);
    check_scan("m2busy", 2, 9999, 0);
    chk("m2_done37", 64'({a_done[37], a_busy[37], a_valid[37]}), 64'b100);
    chk("m2_after", 64'({a_valid[38], a_valid[39], a_valid[40], a_done[38]}), 64'b0000);

`ifdef DW_SCAN_STRIDE2_EN
    // stride 2 on a 4x4 map: centers (0,0),(0,2),(2,0),(2,2)
    start_scan(4, 1'b1);
    capture(38, -1, -1, -1, 0);
    chk("s2_p0", 64'({a_i[1], a_prov[1]}), 64'({15'd0, 2'b11}));
    chk("s2_p1", 64'({a_i[10], a_prov[10]}), 64'({15'd2, 2'b00}));
    chk("s2_p2", 64'({a_i[19], a_prov[19]}), 64'({15'd8, 2'b11}));
    chk("s2_p3", 64'({a_i[28], a_prov[28]}), 64'({15'd10, 2'b00}));
    chk("s2_done", 64'({a_valid[36], a_done[36], a_done[37], a_valid[37]}), 64'b1010);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dw_scan_ctrl.md
# dw_scan_ctrl

Raster scan controller for the depthwise-convolution stage. After a start pulse it walks every output pixel of a square feature map of side `matrix`. For each pixel it issues the nine 3x3 tap addresses, each with a zero-pad flag, and emits the pixel index `i` with its `prov` border code (00 center, 11 left, 10 right). It sits directly upstream of the border/DW MAC path, which consumes `i`, `prov` and the tap stream.

## Interface
Parameters:
- `ADDR_W`, default 15: pixel/tap address width.
- `SIZE_W`, default 7: feature map size width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `go` in 1: start pulse, sampled only in IDLE.
- `matrix` in SIZE_W: feature map side length, latched on accepted `go`.
- `stall` in 1: downstream hold; freezes all scan state.
- `busy` out 1: high in SCAN.
- `tap_valid` out 1: `tap_addr`/`tap_pad`/`tap_idx` valid this cycle.
- `tap_idx` out 4: tap number 0..8.
- `tap_addr` out ADDR_W: input-map address of the tap; 0 when padded.
- `tap_pad` out 1: tap lies outside the map, so the consumer uses 0.
- `i` out ADDR_W: center pixel index of the current output pixel.
- `prov` out 2: border code of `i`.
- `pix_valid` out 1: high on the last tap (`tap_idx`==8) of each pixel.
- `done` out 1: one-cycle pulse at end of scan.

## Operation
- FSM states:
  - IDLE: on `go`, latch `matrix`. If the latched value is nonzero, go to SCAN; if it is 0, go to DONE.
  - SCAN: runs until the last tap of the last pixel is accepted, then goes to DONE.
  - DONE: asserts `done` for one cycle, then goes to IDLE.
- `go` is ignored outside IDLE. Later changes to `matrix` are ignored until the next accepted `go`.
- Counters: row `r`, column `c`, tap `t`, and row base `rb = r*matrix`. Keep these as running sums; no divider or multiplier in the datapath.
- Tap order `t` = 0..8 maps to (dy,dx), row-major, with dy,dx in {-1,0,+1}.
- Pad rule: `tap_pad`=1 iff r+dy<0, r+dy>=matrix, c+dx<0 or c+dx>=matrix. Otherwise `tap_addr` = rb + dy*matrix + c + dx.
- Border code:
  - `prov`=11 if c==0.
  - Else `prov`=10 if c==matrix-1.
  - Else `prov`=00.
  - Left takes priority, so matrix==1 gives 11.
- `i` = rb + c. It and `prov` are held for all nine taps of a pixel.
- Stepping:
  - Each SCAN cycle with `stall`=0 advances `t`.
  - On t==8, `t` returns to 0 and `c` advances.
  - At the end of a row, `c` returns to 0, `r` advances and `rb` += matrix.
- Arithmetic: signed intermediates are SIZE_W+2 bits wide. `tap_addr` never exceeds matrix*matrix-1 (at most 16128 for SIZE_W=7).

## Timing
- Reset values: `busy`, `tap_valid`, `pix_valid`, `done` = 0; `tap_idx`, `tap_addr`, `tap_pad`, `i`, `prov` = 0; state IDLE.
- `go` sampled at edge 0 → `busy`/`tap_valid` high from cycle 1 with tap 0 of pixel 0 (registered outputs, one-cycle latency).
- With no stall, the scan takes matrix*matrix*9 tap cycles. `done` is high on the cycle after the final tap; `busy` is low on that cycle.
- `stall`=1: every output holds its value, and `tap_valid` stays high. A tap counts as accepted only in a cycle with `tap_valid`=1 and `stall`=0.
- `stall` in IDLE or DONE has no effect. A `done` pulse is never extended by `stall`.
- `rst_n` low mid-scan: all outputs clear immediately and the state returns to IDLE. No `done` is issued.
- `go` in the same cycle as `done` is ignored; `go` is accepted from the following cycle.

## Configuration
- `DW_SCAN_STRIDE2_EN` defined: adds input port `stride2` (1 bit), latched with `go`.
  - When `stride2`=1, only centers with even r and even c are visited: `c`/`r` step by 2 and `rb` += 2*matrix.
  - Pixel count becomes ceil(matrix/2)^2. `prov` and the pad rules are unchanged.
  - `prov`=10 when c==matrix-1 can then occur only for odd matrix.
- Undefined: no `stride2` port; stride is fixed at 1.

## Test plan
- matrix=3, `go` at cycle 0, no stall → 81 tap cycles (1..81), `done` at cycle 82, then `busy`=0.
  - Pixel 0: pads on taps 0,1,2,3,6; taps 4,5,7,8 → addr 0,1,3,4; `prov`=11.
  - Pixel 2: `prov`=10.
  - Pixel 4: no pads, addresses 0..8.
- matrix=1 → one pixel, `i`=0, `prov`=11, only tap 4 unpadded (addr 0), `done` at cycle 10.
- matrix=3, `stall` high for 5 cycles at tap 4 of pixel 4 → outputs frozen at addr 4, the sequence resumes unchanged, and `done` is delayed by exactly 5 cycles.
- matrix=4, `rst_n` pulsed low during pixel 6 → all outputs 0 that cycle, no `done`. A new `go` restarts from pixel 0.
- matrix=0 `go` → `done` pulse at cycle 1, `tap_valid` never asserted. A `go` while busy is ignored, leaving the scan unchanged.
- `DW_SCAN_STRIDE2_EN`, matrix=4, `stride2`=1 → `i` = 0,2,8,10, `prov` = 11,00,11,00, 36 tap cycles.
